// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, op codes and flag bit positions.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned FLAGS_W = 3;

  // ALU op codes
  localparam logic [CTRL_W-1:0] ADD    = 3'b000;
  localparam logic [CTRL_W-1:0] SUB    = 3'b001;
  localparam logic [CTRL_W-1:0] AND_OR = 3'b010;
  localparam logic [CTRL_W-1:0] XOR    = 3'b011;
  localparam logic [CTRL_W-1:0] SRA    = 3'b100;
  localparam logic [CTRL_W-1:0] SLA    = 3'b101;
  localparam logic [CTRL_W-1:0] SRL    = 3'b110;
  localparam logic [CTRL_W-1:0] SLL    = 3'b111;

  // Flag bit indices
  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;

endpackage

// File: rtl/alu.sv
// Combinational ALU. sign selects the variant:
//   ADD/SUB : sign=1 -> V is signed overflow, sign=0 -> V is carry (ADD) / borrow (SUB)
//   AND_OR  : sign=0 -> AND, sign=1 -> OR
//   SLA     : V set when the result sign differs from the sign of src_a
//   others  : sign ignored, V=0
// Shift amount is src_b[4:0].
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic               sign,
  input  logic [CTRL_W-1:0]  ctrl,
  output logic [DATA_W-1:0]  result,
  output logic [FLAGS_W-1:0] flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [4:0]      shamt;
  logic            ovf;

  // Operation select plus N/Z/V flag generation
  always_comb begin
    sum    = {1'b0, src_a} + {1'b0, src_b};
    diff   = {1'b0, src_a} - {1'b0, src_b};
    shamt  = src_b[4:0];
    result = '0;
    ovf    = 1'b0;
    case (ctrl)
      ADD: begin
        result = sum[DATA_W-1:0];
        ovf    = sign ? ((src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                         (sum[DATA_W-1] != src_a[DATA_W-1]))
                      : sum[DATA_W];
      end
      SUB: begin
        result = diff[DATA_W-1:0];
        ovf    = sign ? ((src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                         (diff[DATA_W-1] != src_a[DATA_W-1]))
                      : diff[DATA_W];
      end
      AND_OR: result = sign ? (src_a | src_b) : (src_a & src_b);
      XOR:    result = src_a ^ src_b;
      SRA:    result = $signed(src_a) >>> shamt;
      SLA: begin
        result = src_a << shamt;
        ovf    = result[DATA_W-1] != src_a[DATA_W-1];
      end
      SRL:    result = src_a >> shamt;
      default: result = src_a << shamt;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// One op in flight: IDLE (grant/capture) -> EXEC (ALU) -> RESP (hold until ack).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [DATA_W*NUM_REQ-1:0]  req_src_a_i,
  input  logic [DATA_W*NUM_REQ-1:0]  req_src_b_i,
  input  logic [NUM_REQ-1:0]         req_sign_i,
  input  logic [CTRL_W*NUM_REQ-1:0]  req_ctrl_i,
  output logic [NUM_REQ-1:0]         resp_valid_o,
  input  logic [NUM_REQ-1:0]         resp_ready_i,
  output logic [DATA_W-1:0]          resp_result_o,
  output logic [FLAGS_W-1:0]         resp_flags_o,
  output logic                       busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // First valid requester at or after ptr, wrapping at NUM_REQ
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && valid[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt_q;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  logic                 sign_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [DATA_W-1:0]    result_q;
  logic [FLAGS_W-1:0]   flags_q;

  logic [IDX_W-1:0]     gnt;
  logic                 grant_en;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [NUM_REQ-1:0]   gnt_q_oh;
  logic [DATA_W-1:0]    alu_result;
  logic [FLAGS_W-1:0]   alu_flags;

  // Grant decode; ready is suppressed while reset is asserted so no pulse escapes
  always_comb begin
    gnt         = rr_pick(req_valid_i, rr_ptr);
    grant_en    = rst_ni && (state == IDLE) && (|req_valid_i);
    gnt_oh      = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
    gnt_q_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
    req_ready_o = grant_en ? gnt_oh : '0;
  end

  alu u_alu (
    .src_a  (a_q),
    .src_b  (b_q),
    .sign   (sign_q),
    .ctrl   (ctrl_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Arbitration FSM with operand capture and response holding
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= 1'b0;
      ctrl_q       <= '0;
      resp_valid_q <= '0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            gnt_q  <= gnt;
            a_q    <= req_src_a_i[int'(gnt)*DATA_W +: DATA_W];
            b_q    <= req_src_b_i[int'(gnt)*DATA_W +: DATA_W];
            sign_q <= req_sign_i[gnt];
            ctrl_q <= req_ctrl_i[int'(gnt)*CTRL_W +: CTRL_W];
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= alu_result;
          flags_q      <= alu_flags;
          resp_valid_q <= gnt_q_oh;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready_i[gnt_q]) begin
            resp_valid_q <= '0;
            rr_ptr       <= (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + IDX_W'(1);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = result_q;
  assign resp_flags_o  = flags_q;
  assign busy_o        = (state != IDLE);

endmodule
